// File: rtl/apb_rr_master_pkg.sv
// Shared types and helpers for the round-robin APB4 requester.
package apb_rr_master_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_e;

  function automatic int strb_width(input int data_width);
    return data_width / 8;
  endfunction

endpackage

// File: rtl/apb_rr_master_rr_arbiter.sv
// Round-robin arbiter: grants the first request at or above the pointer (with wrap);
// the pointer moves just past the winner whenever a grant is taken.
module rr_arbiter #(
  parameter int NUM_REQ = 2
) (
  input  logic               gclk,
  input  logic               grst_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic               en,
  input  logic               adv,
  output logic [NUM_REQ-1:0] gnt
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PW-1:0] r_ptr;
  logic [PW-1:0] w_ptr_nxt;
  logic          w_found;

  function automatic int wrap(input int v);
    return (v >= NUM_REQ) ? v - NUM_REQ : v;
  endfunction

  always_comb begin
    gnt       = '0;
    w_ptr_nxt = r_ptr;
    w_found   = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (en && !w_found && req[wrap(int'(r_ptr) + k)]) begin
        gnt[wrap(int'(r_ptr) + k)] = 1'b1;
        w_ptr_nxt = PW'(wrap(int'(r_ptr) + k + 1));
        w_found   = 1'b1;
      end
    end
  end

  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n)  r_ptr <= '0;
    else if (adv) r_ptr <= w_ptr_nxt;
  end

endmodule

// File: rtl/apb_rr_master.sv
// APB4 requester sharing one completer among NUM_REQ command sources, with
// round-robin arbitration, back-to-back transfers and an optional stall watchdog.
module apb_rr_master
  import apb_rr_master_pkg::*;
#(
  parameter int NUM_REQ    = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 0,
  localparam int SW        = strb_width(DATA_WIDTH)
) (
  input  logic                                PCLK,
  input  logic                                PRESETn,
  input  logic [NUM_REQ-1:0]                  req_valid,
  output logic [NUM_REQ-1:0]                  req_ready,
  input  logic [NUM_REQ-1:0]                  req_write,
  input  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0]  req_addr,
  input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]  req_wdata,
  input  logic [NUM_REQ-1:0][SW-1:0]          req_strb,
  output logic [NUM_REQ-1:0]                  rsp_valid,
  output logic [DATA_WIDTH-1:0]               rsp_rdata,
  output logic                                rsp_slverr,
  output logic                                rsp_timeout,
  output logic                                PSEL,
  output logic                                PENABLE,
  output logic                                PWRITE,
  output logic [ADDR_WIDTH-1:0]               PADDR,
  output logic [DATA_WIDTH-1:0]               PWDATA,
  output logic [SW-1:0]                       PSTRB,
  input  logic [DATA_WIDTH-1:0]               PRDATA,
  input  logic                                PREADY,
  input  logic                                PSLVERR
);

  typedef struct packed {
    logic                  write;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
    logic [SW-1:0]         strb;
  } cmd_t;

  apb_state_e r_state, w_state_nxt;
  cmd_t       r_cmd, w_cmd_sel;

  logic [NUM_REQ-1:0]    r_owner;
  logic [NUM_REQ-1:0]    w_req_m;
  logic [NUM_REQ-1:0]    w_gnt;
  logic                  w_win;
  logic                  w_accept;
  logic                  w_done;
  logic                  w_abort;

  logic [NUM_REQ-1:0]    r_rsp_valid;
  logic [DATA_WIDTH-1:0] r_rsp_rdata;
  logic                  r_rsp_slverr;
  logic                  r_rsp_timeout;

  // Accept window: idle, or the cycle the current transfer completes.
  assign w_win    = (r_state == IDLE) | ((r_state == ACCESS) & PREADY);
  assign w_done   = (r_state == ACCESS) & PREADY;
  assign w_req_m  = req_valid & ~((r_state == IDLE) ? '0 : r_owner);
  assign w_accept = |w_gnt;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .gclk   (PCLK),
    .grst_n (PRESETn),
    .req    (w_req_m),
    .en     (w_win & PRESETn),
    .adv    (w_accept),
    .gnt    (w_gnt)
  );

  assign req_ready = w_gnt;

  // Reads never expose the requester's write data or strobes on the bus.
  always_comb begin
    w_cmd_sel = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_gnt[i]) begin
        w_cmd_sel.write = req_write[i];
        w_cmd_sel.addr  = req_addr[i];
        w_cmd_sel.wdata = req_write[i] ? req_wdata[i] : '0;
        w_cmd_sel.strb  = req_write[i] ? req_strb[i]  : '0;
      end
    end
  end

  generate
    if (TIMEOUT > 0) begin : g_wd
      localparam int WD_W = $clog2(TIMEOUT + 1);
      logic [WD_W-1:0] r_wd_cnt;

      assign w_abort = (r_state == ACCESS) & ~PREADY & (r_wd_cnt == WD_W'(TIMEOUT - 1));

      always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn)                                           r_wd_cnt <= '0;
        else if ((r_state == ACCESS) && !PREADY && !w_abort)    r_wd_cnt <= r_wd_cnt + WD_W'(1);
        else                                                    r_wd_cnt <= '0;
      end
    end else begin : g_no_wd
      assign w_abort = 1'b0;
    end
  endgenerate

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_state_nxt = SETUP;
      SETUP:   w_state_nxt = ACCESS;
      ACCESS: begin
        if (PREADY)       w_state_nxt = w_accept ? SETUP : IDLE;
        else if (w_abort) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_state       <= IDLE;
      r_cmd         <= '0;
      r_owner       <= '0;
      r_rsp_valid   <= '0;
      r_rsp_rdata   <= '0;
      r_rsp_slverr  <= 1'b0;
      r_rsp_timeout <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_cmd   <= w_cmd_sel;
        r_owner <= w_gnt;
      end
      r_rsp_valid   <= (w_done | w_abort) ? r_owner : '0;
      r_rsp_rdata   <= (w_done & ~r_cmd.write) ? PRDATA : '0;
      r_rsp_slverr  <= (w_done & PSLVERR) | w_abort;
      r_rsp_timeout <= w_abort;
    end
  end

  // Phase strobes decode the async-reset state so they drop immediately on reset.
  assign PSEL        = (r_state != IDLE);
  assign PENABLE     = (r_state == ACCESS);
  assign PWRITE      = r_cmd.write;
  assign PADDR       = r_cmd.addr;
  assign PWDATA      = r_cmd.wdata;
  assign PSTRB       = r_cmd.strb;
  assign rsp_valid   = r_rsp_valid;
  assign rsp_rdata   = r_rsp_rdata;
  assign rsp_slverr  = r_rsp_slverr;
  assign rsp_timeout = r_rsp_timeout;

endmodule

// File: tb/tb_apb_rr_master.sv
// Directed bench for apb_rr_master: two requesters, watchdog of 8 ACCESS cycles.
module tb_apb_rr_master;

  logic              PCLK, PRESETn;
  logic [1:0]        req_valid, req_ready, req_write, rsp_valid;
  logic [1:0][31:0]  req_addr, req_wdata;
  logic [1:0][3:0]   req_strb;
  logic [31:0]       rsp_rdata, PADDR, PWDATA, PRDATA, prd_val;
  logic              rsp_slverr, rsp_timeout, PSEL, PENABLE, PWRITE, PREADY, PSLVERR, prd_echo;
  logic [3:0]        PSTRB;

  int n_chk = 0;
  int n_fail = 0;

  logic [1:0]  exp_g [4] = '{2'b10, 2'b01, 2'b10, 2'b01};
  logic [31:0] exp_a [4] = '{32'h200, 32'h100, 32'h200, 32'h100};

  assign PRDATA = prd_echo ? PADDR : prd_val;

  apb_rr_master #(.NUM_REQ(2), .ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT(8)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_strb(req_strb),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_slverr(rsp_slverr),
    .rsp_timeout(rsp_timeout), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA), .PSTRB(PSTRB), .PRDATA(PRDATA),
    .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge PCLK);
    #1;
  endtask

  initial begin
    PRESETn = 1'b0; req_valid = 2'b11; req_write = '0; req_addr = '0;
    req_wdata = '0; req_strb = '0; PREADY = 1'b1; PSLVERR = 1'b0;
    prd_echo = 1'b0; prd_val = '0;
    #1;
    chk("rst_ready", req_ready, 2'b00);
    step(); step();
    chk("rst_phase", {PSEL, PENABLE}, 2'b00);
    chk("rst_rsp", rsp_valid, 2'b00);
    chk("rst_paddr", PADDR, 32'h0);
    PRESETn = 1'b1; req_valid = 2'b00;
    step();

    // single write
    req_valid = 2'b01; req_write = 2'b01; req_addr[0] = 32'h10;
    req_wdata[0] = 32'hDEADBEEF; req_strb[0] = 4'hF; #1;
    chk("wr_ready", req_ready, 2'b01);
    step(); req_valid = 2'b00;
    chk("wr_setup", {PSEL, PENABLE}, 2'b10);
    chk("wr_cmd", {PWRITE, PADDR}, {1'b1, 32'h10});
    chk("wr_data", {PWDATA, PSTRB}, {32'hDEADBEEF, 4'hF});
    step();
    chk("wr_access", {PSEL, PENABLE}, 2'b11);
    chk("wr_no_rsp", rsp_valid, 2'b00);
    step();
    chk("wr_rsp", {rsp_valid, rsp_slverr, rsp_timeout}, {2'b01, 1'b0, 1'b0});
    chk("wr_rdata", rsp_rdata, 32'h0);
    chk("wr_idle", PSEL, 1'b0);

    // fairness: continuous reads from both, pointer now at 1
    req_write = 2'b00; req_addr[0] = 32'h100; req_addr[1] = 32'h200;
    prd_echo = 1'b1; req_valid = 2'b11; #1;
    chk("rr_first", req_ready, 2'b10);
    step();
    for (int i = 0; i < 4; i++) begin
      chk("rr_setup", {PSEL, PENABLE}, 2'b10);
      chk("rr_paddr", PADDR, exp_a[i]);
      if (i > 0) begin
        chk("rr_rsp", rsp_valid, exp_g[i-1]);
        chk("rr_rdata", rsp_rdata, exp_a[i-1]);
      end
      step();
      chk("rr_access", {PSEL, PENABLE}, 2'b11);
      if (i == 3) begin
        req_valid = 2'b00; #1;
        chk("rr_last_ready", req_ready, 2'b00);
      end else begin
        chk("rr_next", req_ready, exp_g[i+1]);
      end
      step();
    end
    chk("rr_rsp_end", rsp_valid, 2'b01);
    chk("rr_rdata_end", rsp_rdata, 32'h100);
    chk("rr_idle", PSEL, 1'b0);
    prd_echo = 1'b0;

    // wait states on a write from requester 1
    PREADY = 1'b0; req_valid = 2'b10; req_write = 2'b10; req_addr[1] = 32'h300;
    req_wdata[1] = 32'h12345678; req_strb[1] = 4'h5; #1;
    chk("ws_ready", req_ready, 2'b10);
    step(); req_valid = 2'b00;
    chk("ws_setup", {PSEL, PENABLE}, 2'b10);
    step();
    for (int c = 0; c < 4; c++) begin
      if (c == 3) begin PREADY = 1'b1; #1; end
      chk("ws_phase", {PSEL, PENABLE}, 2'b11);
      chk("ws_cmd", {PWRITE, PADDR}, {1'b1, 32'h300});
      chk("ws_data", {PWDATA, PSTRB}, {32'h12345678, 4'h5});
      chk("ws_no_rsp", rsp_valid, 2'b00);
      step();
    end
    chk("ws_rsp", {rsp_valid, rsp_slverr}, {2'b10, 1'b0});
    chk("ws_idle", PSEL, 1'b0);
    step();
    chk("ws_one_rsp", rsp_valid, 2'b00);

    // read with slave error; write data/strobes must be suppressed
    req_valid = 2'b01; req_write = 2'b00; req_addr[0] = 32'h40;
    req_wdata[0] = 32'hFFFFFFFF; req_strb[0] = 4'hF; prd_val = 32'hCAFEF00D; #1;
    chk("rd_ready", req_ready, 2'b01);
    step(); req_valid = 2'b00;
    chk("rd_cmd", {PWRITE, PADDR}, {1'b0, 32'h40});
    chk("rd_data", {PWDATA, PSTRB}, {32'h0, 4'h0});
    step(); PSLVERR = 1'b1;
    step(); PSLVERR = 1'b0;
    chk("rd_rsp", {rsp_valid, rsp_slverr, rsp_timeout}, {2'b01, 1'b1, 1'b0});
    chk("rd_rdata", rsp_rdata, 32'hCAFEF00D);

    // watchdog abort, then the queued request is served normally
    PREADY = 1'b0; req_valid = 2'b11; req_addr[1] = 32'h500; req_addr[0] = 32'h600; #1;
    chk("wd_ready", req_ready, 2'b10);
    step(); req_valid = 2'b01;
    chk("wd_setup_ready", req_ready, 2'b00);
    step();
    for (int c = 0; c < 8; c++) begin
      chk("wd_phase", {PSEL, PENABLE}, 2'b11);
      chk("wd_no_ready", req_ready, 2'b00);
      step();
    end
    chk("wd_abort_phase", {PSEL, PENABLE}, 2'b00);
    chk("wd_rsp", {rsp_valid, rsp_slverr, rsp_timeout}, {2'b10, 1'b1, 1'b1});
    chk("wd_rdata", rsp_rdata, 32'h0);
    chk("wd_next_ready", req_ready, 2'b01);
    PREADY = 1'b1; prd_val = 32'h77;
    step(); req_valid = 2'b00;
    chk("wd_next_setup", {PSEL, PENABLE}, 2'b10);
    chk("wd_next_paddr", PADDR, 32'h600);
    step(); step();
    chk("wd_next_rsp", {rsp_valid, rsp_slverr, rsp_timeout}, {2'b01, 1'b0, 1'b0});
    chk("wd_next_rdata", rsp_rdata, 32'h77);

    // reset in ACCESS
    PREADY = 1'b0; req_valid = 2'b10; req_write = 2'b10; req_addr[1] = 32'h700; #1;
    chk("rs_ready", req_ready, 2'b10);
    step(); req_valid = 2'b00;
    step();
    chk("rs_access", {PSEL, PENABLE}, 2'b11);
    #2 PRESETn = 1'b0; req_valid = 2'b11;
    #1;
    chk("rs_async_drop", {PSEL, PENABLE}, 2'b00);
    chk("rs_ready_low", req_ready, 2'b00);
    step();
    chk("rs_no_rsp0", rsp_valid, 2'b00);
    step();
    chk("rs_no_rsp1", rsp_valid, 2'b00);
    PRESETn = 1'b1; req_write = 2'b00; req_addr[0] = 32'h800; PREADY = 1'b1; #1;
    chk("rs_ptr0", req_ready, 2'b01);
    step(); req_valid = 2'b00;
    chk("rs_paddr", PADDR, 32'h800);
    chk("rs_no_rsp2", rsp_valid, 2'b00);
    step(); step();
    chk("rs_rsp", rsp_valid, 2'b01);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
